mem_io_responder: RTL and testbench

Responder end of the CPU byte-wide memory bus: decodes each CPU access (address, write data, write strobe), forwards RAM accesses to the external RAM macro and serves memory-mapped I/O itself. It owns the UART TX FIFO, the RX pop path, the cycle counter and the program-stop flag, and drives `cpu_din` (next-cycle read data) and `io_buffer_full` back to the CPU. It sits between the CPU top and the RAM/UART blocks.

---
 rtl/mem_io_responder.sv | 200 ++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder side of the CPU byte-wide memory bus.
// RAM accesses are forwarded combinationally to the external RAM macro.
// The top quarter of the 18-bit decode space (cpu_a[17:16] == 2'b11) is
// memory-mapped I/O served locally:
//   0x30000  read: pop a received UART byte (0x00 if none)
//            write: queue a non-zero byte for transmission
//   0x30004  read: snapshot the cycle counter, return byte 0
//            write: raise program_done and queue a 0x00 terminator
//   0x30005..0x30007  read: snapshot bytes 1..3
// Read data for an access appears on cpu_din in the following cycle.
module mem_io_responder #(
    parameter int TX_DEPTH = 16,
    parameter int RAM_AW   = 17
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              program_done
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(TX_DEPTH + 1);

    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CNT0 = 18'h30004;
    localparam logic [17:0] ADDR_CNT1 = 18'h30005;
    localparam logic [17:0] ADDR_CNT2 = 18'h30006;
    localparam logic [17:0] ADDR_CNT3 = 18'h30007;

    // ------------------------------------------------------------------
    // Reset conditioning: assertion is immediate, release is aligned to
    // clk_in so every register leaves reset on the same edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // two-stage release synchroniser
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [17:0] io_addr;
    logic        io_sel;
    logic        io_rd;
    logic        io_wr;
    logic        hit_uart;
    logic        hit_cnt0;
    logic        unused_addr_bits;

    assign io_addr  = cpu_a[17:0];
    assign io_sel   = (cpu_a[17:16] == 2'b11);
    assign io_rd    = rdy_in & io_sel & ~cpu_wr;
    assign io_wr    = rdy_in & io_sel & cpu_wr;
    assign hit_uart = (io_addr == ADDR_UART);
    assign hit_cnt0 = (io_addr == ADDR_CNT0);

    // upper CPU address bits are not decoded
    assign unused_addr_bits = ^cpu_a[31:18];

    // ------------------------------------------------------------------
    // RAM pass-through
    // ------------------------------------------------------------------
    assign ram_en    = rdy_in & ~io_sel;
    assign ram_we    = ram_en & cpu_wr;
    assign ram_a     = cpu_a[RAM_AW-1:0];
    assign ram_wdata = cpu_dout;

    // ------------------------------------------------------------------
    // IO read data and bookkeeping registers
    // ------------------------------------------------------------------
    logic        sel_q;
    logic [7:0]  io_rdata_q;
    logic [7:0]  io_rdata_next;
    logic [31:0] cycle_cnt;
    logic [31:0] snapshot;
    logic        program_done_q;

    // select the byte an IO read will return next cycle
    always_comb begin
        io_rdata_next = 8'h00;
        case (io_addr)
            ADDR_UART: io_rdata_next = rx_valid ? rx_data : 8'h00;
            ADDR_CNT0: io_rdata_next = cycle_cnt[7:0];
            ADDR_CNT1: io_rdata_next = snapshot[15:8];
            ADDR_CNT2: io_rdata_next = snapshot[23:16];
            ADDR_CNT3: io_rdata_next = snapshot[31:24];
            default:   io_rdata_next = 8'h00;
        endcase
    end

    // accepted-access state: read path select, IO data, counter, stop flag
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sel_q          <= 1'b1;
            io_rdata_q     <= 8'h00;
            cycle_cnt      <= 32'h0000_0000;
            snapshot       <= 32'h0000_0000;
            program_done_q <= 1'b0;
        end else if (rdy_in) begin
            sel_q     <= io_sel;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (io_rd) begin
                io_rdata_q <= io_rdata_next;
            end
            // the byte-0 read latches the whole counter so the remaining
            // bytes of a dword read come from the same instant
            if (io_rd && hit_cnt0) begin
                snapshot <= cycle_cnt;
            end
            if (io_wr && hit_cnt0) begin
                program_done_q <= 1'b1;
            end
        end
    end

    assign cpu_din      = sel_q ? io_rdata_q : ram_rdata;
    assign program_done = program_done_q;

    // pop the receiver only on a real UART read; held low while in reset
    assign rx_ready = rst_n & io_rd & hit_uart & rx_valid;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_req;
    logic [7:0]    push_data;
    logic          push;
    logic          pop;
    logic          fifo_full;

    assign push_req  = io_wr & ((hit_uart & (cpu_dout != 8'h00)) | hit_cnt0);
    assign push_data = hit_cnt0 ? 8'h00 : cpu_dout;
    assign fifo_full = (count == CW'(TX_DEPTH));
    assign pop       = tx_valid & tx_ready;
    // a push into a full FIFO is kept only when the head leaves this cycle
    assign push      = push_req & (~fifo_full | pop);

    // storage; contents are only visible through the count-qualified head
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign tx_valid       = (count != '0);
    assign tx_data        = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    // two entries of headroom for CPU writes already in flight
    assign io_buffer_full = (count >= CW'(TX_DEPTH - 2));

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios followed by random traffic,
// all checked against a transaction-level model (byte queue for the TX FIFO,
// byte array for RAM, plain counters for cycle count and stop flag).
module tb_mem_io_responder;

    localparam int TX_DEPTH = 16;
    localparam int RAM_AW   = 17;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              rdy_in;
    logic [31:0]       cpu_a;
    logic [7:0]        cpu_dout;
    logic              cpu_wr;
    logic [7:0]        cpu_din;
    logic              io_buffer_full;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_a;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              program_done;

    mem_io_responder #(.TX_DEPTH(TX_DEPTH), .RAM_AW(RAM_AW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_done(program_done)
    );

    always #5 clk_in = ~clk_in;

    // external RAM macro: synchronous read, data held until next read
    bit [7:0] emu_ram [0:(1<<RAM_AW)-1];
    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_we) emu_ram[ram_a] <= ram_wdata;
            else        ram_rdata <= emu_ram[ram_a];
        end
    end

    // reference model state
    logic [7:0]  mq[$];
    bit   [7:0]  m_ram [0:(1<<RAM_AW)-1];
    logic        m_done;
    logic [31:0] m_cyc;
    logic [31:0] m_snap;
    logic [7:0]  m_din;
    bit          m_din_known;

    int n_asserts = 0;
    int n_fails   = 0;

    // observations from the most recent step
    logic [7:0] obs_din;
    logic       obs_rx_ready;
    logic       obs_full;
    logic       obs_done;
    logic       obs_tx_valid;
    logic [7:0] obs_tx_data;
    logic [7:0] drained[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_done      = 1'b0;
        m_cyc       = 32'd0;
        m_snap      = 32'd0;
        m_din       = 8'h00;
        m_din_known = 1'b1;
    endtask

    task automatic set_acc(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d);
        rdy_in   = rdy;
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
    endtask

    // one clock: inputs are already driven; check at negedge, advance model
    task automatic step();
        logic        io;
        logic [17:0] off;
        logic        do_push;
        logic [7:0]  pb;
        @(negedge clk_in);
        io  = (cpu_a[17:16] == 2'b11);
        off = cpu_a[17:0];
        check("ram_en", ram_en, rdy_in & ~io);
        check("ram_we", ram_we, rdy_in & ~io & cpu_wr);
        if (rdy_in && !io) begin
            check("ram_a", ram_a, cpu_a[RAM_AW-1:0]);
            check("ram_wdata", ram_wdata, cpu_dout);
        end
        check("rx_ready", rx_ready, rdy_in & io & ~cpu_wr & (off == 18'h30000) & rx_valid);
        check("tx_valid", tx_valid, mq.size() != 0);
        check("tx_data", tx_data, (mq.size() != 0) ? mq[0] : 8'h00);
        check("io_buffer_full", io_buffer_full, mq.size() >= TX_DEPTH - 2);
        check("program_done", program_done, m_done);
        if (m_din_known) check("cpu_din", cpu_din, m_din);

        obs_din      = cpu_din;
        obs_rx_ready = rx_ready;
        obs_full     = io_buffer_full;
        obs_done     = program_done;
        obs_tx_valid = tx_valid;
        obs_tx_data  = tx_data;
        if (tx_valid && tx_ready) drained.push_back(tx_data);

        if (mq.size() != 0 && tx_ready) void'(mq.pop_front());
        do_push = 1'b0;
        pb      = 8'h00;
        if (rdy_in && io && cpu_wr) begin
            if (off == 18'h30000 && cpu_dout != 8'h00) begin
                do_push = 1'b1;
                pb      = cpu_dout;
            end else if (off == 18'h30004) begin
                do_push = 1'b1;
                pb      = 8'h00;
                m_done  = 1'b1;
            end
        end
        if (do_push && mq.size() < TX_DEPTH) mq.push_back(pb);

        if (rdy_in) begin
            if (!io) begin
                if (cpu_wr) begin
                    m_ram[cpu_a[RAM_AW-1:0]] = cpu_dout;
                    m_din_known = 1'b0;
                end else begin
                    m_din = m_ram[cpu_a[RAM_AW-1:0]];
                    m_din_known = 1'b1;
                end
            end else if (cpu_wr) begin
                m_din_known = 1'b0;
            end else begin
                m_din_known = 1'b1;
                case (off)
                    18'h30000: m_din = rx_valid ? rx_data : 8'h00;
                    18'h30004: begin m_snap = m_cyc; m_din = m_cyc[7:0]; end
                    18'h30005: m_din = m_snap[15:8];
                    18'h30006: m_din = m_snap[23:16];
                    18'h30007: m_din = m_snap[31:24];
                    default:   m_din = 8'h00;
                endcase
            end
            m_cyc = m_cyc + 32'd1;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        set_acc(1'b0, 32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        rst_n_in = 1'b0;
        #1;
        model_reset();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_program_done", program_done, 1'b0);
        check("rst_cpu_din", cpu_din, 8'h00);
        check("rst_io_buffer_full", io_buffer_full, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b0);
        repeat (2) step();
        rst_n_in = 1'b1;
        repeat (4) step();
    endtask

    task automatic rand_inputs();
        logic [31:0] r;
        logic        b16;
        logic        b17;
        logic [17:0] ioa;
        r        = $urandom;
        rdy_in   = ($urandom_range(0, 9) != 0);
        tx_ready = $urandom_range(0, 1) != 0;
        rx_valid = $urandom_range(0, 1) != 0;
        rx_data  = 8'($urandom);
        cpu_wr   = $urandom_range(0, 1) != 0;
        cpu_dout = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        if ($urandom_range(0, 1) != 0) begin
            case ($urandom_range(0, 6))
                0, 1:    ioa = 18'h30000;
                2:       ioa = 18'h30004;
                3:       ioa = 18'h30005;
                4:       ioa = 18'h30006;
                5:       ioa = 18'h30007;
                default: ioa = 18'h30008;
            endcase
            cpu_a = {r[31:18], ioa};
        end else begin
            b16   = $urandom_range(0, 1) != 0;
            b17   = b16 ? 1'b0 : ($urandom_range(0, 1) != 0);
            cpu_a = {r[31:18], b17, b16, 11'd0, 5'($urandom_range(0, 31))};
        end
    endtask

    initial begin
        logic [7:0] b0, b1, b2, b3;
        rst_n_in = 1'b0;
        set_acc(1'b0, 32'h0, 1'b0, 8'h00);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        do_reset();

        // RAM write then read back
        set_acc(1'b1, 32'h0000_0010, 1'b1, 8'h55); step();
        set_acc(1'b1, 32'h0000_0010, 1'b0, 8'h00); step();
        set_acc(1'b1, 32'h0000_0000, 1'b0, 8'h00); step();
        check("ram_readback", obs_din, 8'h55);

        // UART TX writes, zero byte ignored
        tx_ready = 1'b1;
        drained.delete();
        set_acc(1'b1, 32'h0003_0000, 1'b1, 8'h41); step();
        set_acc(1'b1, 32'h0003_0000, 1'b1, 8'h00); step();
        set_acc(1'b1, 32'h0003_0000, 1'b1, 8'h42); step();
        set_acc(1'b1, 32'h0000_0000, 1'b0, 8'h00);
        repeat (4) step();
        check("tx_seq_len", drained.size(), 2);
        if (drained.size() == 2) begin
            check("tx_seq_0", drained[0], 8'h41);
            check("tx_seq_1", drained[1], 8'h42);
        end

        // fill FIFO with transmitter stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_acc(1'b1, 32'h0003_0000, 1'b1, 8'h61);
            step();
            if (i == 13) check("full_after_13", obs_full, 1'b0);
            if (i == 14) check("full_after_14", obs_full, 1'b1);
        end
        set_acc(1'b1, 32'h0000_0000, 1'b0, 8'h00); step();
        drained.delete();
        tx_ready = 1'b1;
        repeat (20) step();
        check("drain_count", drained.size(), 16);

        // coherent cycle-counter read
        do_reset();
        set_acc(1'b1, 32'h0000_0000, 1'b0, 8'h00);
        repeat (300) step();
        set_acc(1'b1, 32'h0003_0004, 1'b0, 8'h00); step();
        set_acc(1'b1, 32'h0003_0005, 1'b0, 8'h00); step(); b0 = obs_din;
        set_acc(1'b1, 32'h0003_0006, 1'b0, 8'h00); step(); b1 = obs_din;
        set_acc(1'b1, 32'h0003_0007, 1'b0, 8'h00); step(); b2 = obs_din;
        set_acc(1'b1, 32'h0000_0000, 1'b0, 8'h00); step(); b3 = obs_din;
        check("cnt_snapshot", {b3, b2, b1, b0}, 32'h0000_012C);

        // UART RX pop
        rx_valid = 1'b1; rx_data = 8'h7A;
        set_acc(1'b1, 32'h0003_0000, 1'b0, 8'h00); step();
        check("rx_pulse", obs_rx_ready, 1'b1);
        rx_valid = 1'b0;
        set_acc(1'b1, 32'h0000_0000, 1'b0, 8'h00); step();
        check("rx_data", obs_din, 8'h7A);
        check("rx_single_pulse", obs_rx_ready, 1'b0);
        set_acc(1'b1, 32'h0003_0000, 1'b0, 8'h00); step();
        check("rx_empty_no_pulse", obs_rx_ready, 1'b0);
        set_acc(1'b1, 32'h0000_0000, 1'b0, 8'h00); step();
        check("rx_empty_data", obs_din, 8'h00);

        // program stop gated by rdy_in, then reset mid-drain
        tx_ready = 1'b0;
        set_acc(1'b0, 32'h0003_0004, 1'b1, 8'h00); step();
        set_acc(1'b0, 32'h0000_0000, 1'b0, 8'h00); step();
        check("done_not_ready", obs_done, 1'b0);
        set_acc(1'b1, 32'h0003_0004, 1'b1, 8'h00); step();
        set_acc(1'b0, 32'h0000_0000, 1'b0, 8'h00); step();
        check("done_ready", obs_done, 1'b1);
        check("done_tx_valid", obs_tx_valid, 1'b1);
        check("done_tx_data", obs_tx_data, 8'h00);
        set_acc(1'b1, 32'h0003_0000, 1'b1, 8'h11); step();
        set_acc(1'b1, 32'h0003_0000, 1'b1, 8'h22); step();
        tx_ready = 1'b1;
        set_acc(1'b1, 32'h0000_0000, 1'b0, 8'h00); step();
        do_reset();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
